ifetch_prefetch: RTL and testbench
==================================

// Module: ifetch_prefetch
// PURPOSE
//  Parametrised next-generation fetch unit: decoupled PC generator plus a prefetch FIFO.
//  Issues one word-address request per cycle to a 1-cycle synchronous instruction memory.
//  Buffers {pc, instr} pairs so the decode stage can stall without stalling fetch.
//  Branch redirect flushes the buffer and drops in-flight data. Sits between imem and decode.
// PARAMETERS
//  PC_WIDTH        30            word-address PC width (byte PC = {pc,2'b00})
//  I_DATAWIDTH     32            instruction word width
//  I_ADDRESSWIDTH  8             imem address bits driven (low bits of fetch PC)
//  FIFO_DEPTH      4             prefetch entries; power of two, >=2
//  RESET_PC        30'h0100_0000 first word address fetched after reset (byte 0x0400_0000)
// PORTS
//  clk           in   1               clock
//  resetn        in   1               async active-low reset
//  imem_req      out  1               read request this cycle
//  imem_addr     out  I_ADDRESSWIDTH  word address of request
//  imem_rdata    in   I_DATAWIDTH     data for request issued previous cycle
//  redirect      in   1               load redirect_pc, flush (branch/jump/exception)
//  redirect_pc   in   PC_WIDTH        new word-address PC
//  instr_valid   out  1               FIFO head valid
//  instr_ready   in   1               decode accepts head
//  instr         out  I_DATAWIDTH     head instruction
//  pc_out        out  I_DATAWIDTH     {head_pc+1, 2'b00} (link/return address)
//  opcode,rs,rt,rd,sa,func,offset,instr_index  out  MIPS field slices of instr
//  fifo_count    out  $clog2(FIFO_DEPTH)+1  occupancy (debug/perf)
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, FIFO empty, inflight=0, epoch=0; imem_req=0, instr_valid=0,
//   fifo_count=0, instr/fields = 0 (no stale data visible).
//  Pop: pop = instr_valid & instr_ready & ~redirect.
//  Credit: imem_req = ~redirect & (fifo_count + inflight - pop < FIFO_DEPTH).
//   Guarantees every response has a free slot; no overflow, no response loss.
//  Issue: imem_addr = fetch_pc[I_ADDRESSWIDTH-1:0]; on imem_req, fetch_pc <= fetch_pc+1
//   (wraps modulo 2^PC_WIDTH); inflight<=1, inflight_pc<=fetch_pc, inflight_epoch<=epoch.
//  Response: cycle after issue, if inflight & inflight_epoch==epoch, push {inflight_pc,
//   imem_rdata}. Push and pop in same cycle allowed at any occupancy incl. full.
//  Redirect (priority over everything): fetch_pc<=redirect_pc; FIFO flushed; epoch toggles
//   so in-flight response is discarded; no request and no pop that cycle.
//   First request to redirect_pc next cycle; instr_valid 2 cycles after that.
//  Latency: reset release/redirect -> first instr_valid = 3 cycles; no bypass path.
//  Throughput: 1 instr/cycle sustained while instr_ready=1.
//  Stall: instr_ready=0 holds head stable; fetch continues until FIFO_DEPTH entries
//   (occupancy+inflight) then imem_req=0 until a pop.
//  Reset asserted mid-operation: all state cleared immediately; in-flight data discarded.
//  Fields: opcode=instr[31:26] rs=[25:21] rt=[20:16] rd=[15:11] sa=[10:6] func=[5:0]
//   offset=[15:0] instr_index=[25:0]; all from FIFO head.
// STRUCTURE
//  Package ifetch_pkg: instruction field bit positions, RESET_PC default, PC_WIDTH default.
//  Sub-module fetch_fifo: sync FIFO (push, pop, flush, count, head data), width
//   PC_WIDTH+I_DATAWIDTH, pointer wrap via extra MSB; flush clears pointers same cycle.
//  Top: PC/credit/epoch logic plus field slicing only.
// TESTING
//  1 Reset release, ready=1, imem=addr model -> imem_addr 0x00,0x01,.. each cycle;
//    first valid at cycle 3, pc_out=0x0400_0004, then one instr/cycle in order.
//  2 ready=0 from reset, DEPTH=4 -> exactly 4 requests, fifo_count=4, imem_req=0,
//    head stays pc 0x0100_0000; ready=1 -> resume, no gap after first pop.
//  3 redirect to 0x0000_0040 while inflight & FIFO=3 -> fifo_count=0 next cycle,
//    stale response not pushed; next valid instr has pc_out=0x0000_0104.
//  4 redirect same cycle as valid&ready -> pop suppressed, no request that cycle.
//  5 fetch_pc=0x3FFF_FFFF -> next request wraps to 0, imem_addr=0x00.
//  6 resetn pulsed low with FIFO full -> instr_valid=0, fifo_count=0 asynchronously;
//    restart fetches from RESET_PC.

Source files
------------

// File: rtl/ifetch_prefetch_pkg.sv
// Shared constants for the prefetching fetch unit:
// default PC/reset values and MIPS field bit positions.
package ifetch_pkg;

  localparam int PC_WIDTH_DEF = 30;
  localparam logic [29:0] RESET_PC_DEF = 30'h0100_0000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SA_MSB  = 10;
  localparam int SA_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int OFF_MSB = 15;
  localparam int IDX_MSB = 25;

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Fetch unit bus bundle: imem request/response,
// redirect, and the decode-side valid/ready handshake.
interface ifetch_prefetch_if #(
  parameter int PC_WIDTH       = 30,
  parameter int I_DATAWIDTH    = 32,
  parameter int I_ADDRESSWIDTH = 8
);

  logic                      imem_req;
  logic [I_ADDRESSWIDTH-1:0] imem_addr;
  logic [I_DATAWIDTH-1:0]    imem_rdata;
  logic                      redirect;
  logic [PC_WIDTH-1:0]       redirect_pc;
  logic                      instr_valid;
  logic                      instr_ready;
  logic [I_DATAWIDTH-1:0]    instr;
  logic [I_DATAWIDTH-1:0]    pc_out;

  modport master (
    output imem_req, imem_addr,
    output instr_valid, instr, pc_out,
    input  imem_rdata, redirect,
    input  redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    input  instr_valid, instr, pc_out,
    output imem_rdata, redirect,
    output redirect_pc, instr_ready
  );

endinterface

// File: rtl/ifetch_prefetch_fifo.sv
// Prefetch buffer: sync FIFO with extra-MSB pointers;
// flush empties it in the same cycle and beats push.
module fetch_fifo #(
  parameter int WIDTH = 62,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;

  // Pointer update; flush resets both pointers
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents are masked while empty
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wptr_q[AW-1:0]] <= din;
  end

  assign count = wptr_q - rptr_q;
  assign valid = (count != '0);
  assign dout  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/ifetch_prefetch.sv
// Decoupled PC generator with credit-based issue into
// a prefetch FIFO; redirect flushes via epoch tagging.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int PC_WIDTH       = PC_WIDTH_DEF,
  parameter int I_DATAWIDTH    = 32,
  parameter int I_ADDRESSWIDTH = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC =
    PC_WIDTH'(RESET_PC_DEF)
) (
  input  logic        clk,
  input  logic        resetn,
  ifetch_prefetch_if.master bus,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [5:0]  func,
  output logic [15:0] offset,
  output logic [25:0] instr_index,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = PC_WIDTH + I_DATAWIDTH;

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                inflight_q, inflight_d;
  logic                epoch_q, epoch_d;
  logic                inflight_epoch_q, inflight_epoch_d;

  logic                   pop, push, req;
  logic [CW:0]            occ;
  logic                   head_valid;
  logic [EW-1:0]          head_data;
  logic [PC_WIDTH-1:0]    head_pc;
  logic [PC_WIDTH-1:0]    link_pc;
  logic [I_DATAWIDTH-1:0] instr_w;

  // Credit check, handshake and next-state for PC/epoch
  always_comb begin
    pop  = head_valid & bus.instr_ready & ~bus.redirect;
    push = inflight_q & (inflight_epoch_q == epoch_q)
         & ~bus.redirect;
    occ  = {1'b0, fifo_count}
         + (CW+1)'(inflight_q) - (CW+1)'(pop);
    req  = resetn & ~bus.redirect
         & (occ < (CW+1)'(FIFO_DEPTH));
    fetch_pc_d       = fetch_pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_d       = 1'b0;
    epoch_d          = epoch_q;
    inflight_epoch_d = inflight_epoch_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      epoch_d    = ~epoch_q;
    end else if (req) begin
      fetch_pc_d       = fetch_pc_q + 1'b1;
      inflight_d       = 1'b1;
      inflight_pc_d    = fetch_pc_q;
      inflight_epoch_d = epoch_q;
    end
  end

  // Fetch state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q       <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_q       <= 1'b0;
      epoch_q          <= 1'b0;
      inflight_epoch_q <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_q       <= inflight_d;
      epoch_q          <= epoch_d;
      inflight_epoch_q <= inflight_epoch_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (bus.redirect),
    .din    ({inflight_pc_q, bus.imem_rdata}),
    .dout   (head_data),
    .valid  (head_valid),
    .count  (fifo_count)
  );

  assign head_pc = head_data[EW-1:I_DATAWIDTH];
  assign link_pc = head_pc + 1'b1;
  assign instr_w = head_valid
                 ? head_data[I_DATAWIDTH-1:0] : '0;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q[I_ADDRESSWIDTH-1:0];
  assign bus.instr_valid = head_valid;
  assign bus.instr       = instr_w;
  assign bus.pc_out      = head_valid
                         ? I_DATAWIDTH'({link_pc, 2'b00})
                         : '0;

  assign opcode      = instr_w[OPC_MSB:OPC_LSB];
  assign rs          = instr_w[RS_MSB:RS_LSB];
  assign rt          = instr_w[RT_MSB:RT_LSB];
  assign rd          = instr_w[RD_MSB:RD_LSB];
  assign sa          = instr_w[SA_MSB:SA_LSB];
  assign func        = instr_w[FN_MSB:FN_LSB];
  assign offset      = instr_w[OFF_MSB:0];
  assign instr_index = instr_w[IDX_MSB:0];

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: imem returns
// 0x1234_5600 | addr one cycle after each request.
module tb_ifetch_prefetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic [2:0]  fifo_count;
  int          checks = 0;
  int          failures = 0;

  ifetch_prefetch_if #(
    .PC_WIDTH(30), .I_DATAWIDTH(32), .I_ADDRESSWIDTH(8)
  ) bus ();

  ifetch_prefetch dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .sa          (sa),
    .func        (func),
    .offset      (offset),
    .instr_index (instr_index),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.imem_req)
      bus.imem_rdata <= 32'h1234_5600 | {24'h0, bus.imem_addr};

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic rdy);
    @(negedge clk);
    resetn = 1'b0;
    bus.instr_ready = rdy;
    bus.redirect = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_rdata = '0;
    tick(); tick();
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", bus.imem_req); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", bus.instr_valid); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0h exp=0", fifo_count); end
    checks++; if (bus.instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%0h exp=0", bus.instr); end
    checks++; if (bus.pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc got=%0h exp=0", bus.pc_out); end
    checks++; if (opcode !== 6'h0 || instr_index !== 26'h0) begin failures++; $display("FAIL rst_fields got=%0h/%0h exp=0/0", opcode, instr_index); end
  endtask

  task automatic test_fetch();
    logic [31:0] e_pc, e_in;
    logic [7:0]  e_ad;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin failures++; $display("FAIL fetch_c0 got=%0h/%0h exp=1/0", bus.imem_req, bus.imem_addr); end
    tick();
    checks++; if (bus.imem_addr !== 8'h01 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL fetch_c1 got=%0h/%0h exp=1/0", bus.imem_addr, bus.instr_valid); end
    tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h0400_0004) begin failures++; $display("FAIL fetch_first got=%0h/%0h exp=1/4000004", bus.instr_valid, bus.pc_out); end
    checks++; if (bus.instr !== 32'h1234_5600) begin failures++; $display("FAIL fetch_instr got=%0h exp=12345600", bus.instr); end
    checks++; if (opcode !== 6'd4 || rs !== 5'd17 || rt !== 5'd20) begin failures++; $display("FAIL fields_a got=%0d/%0d/%0d exp=4/17/20", opcode, rs, rt); end
    checks++; if (rd !== 5'd10 || sa !== 5'd24 || func !== 6'd0) begin failures++; $display("FAIL fields_b got=%0d/%0d/%0d exp=10/24/0", rd, sa, func); end
    checks++; if (offset !== 16'h5600 || instr_index !== 26'h234_5600) begin failures++; $display("FAIL fields_c got=%0h/%0h exp=5600/2345600", offset, instr_index); end
    for (int i = 1; i < 7; i++) begin
      tick();
      e_pc = 32'h0400_0004 + 32'(4 * i);
      e_in = 32'h1234_5600 | 32'(i);
      e_ad = 8'(i + 2);
      checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== e_pc) begin failures++; $display("FAIL stream_pc got=%0h/%0h exp=1/%0h", bus.instr_valid, bus.pc_out, e_pc); end
      checks++; if (bus.instr !== e_in || bus.imem_addr !== e_ad) begin failures++; $display("FAIL stream_in got=%0h/%0h exp=%0h/%0h", bus.instr, bus.imem_addr, e_in, e_ad); end
      checks++; if (fifo_count !== 3'd1 || func !== 6'(i)) begin failures++; $display("FAIL stream_cnt got=%0h/%0h exp=1/%0h", fifo_count, func, i); end
    end
  endtask

  task automatic test_stall();
    int nreq = 0;
    logic [31:0] e_pc;
    apply_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      if (bus.imem_req === 1'b1) nreq++;
      tick();
    end
    checks++; if (nreq != 4) begin failures++; $display("FAIL stall_reqs got=%0d exp=4", nreq); end
    checks++; if (fifo_count !== 3'd4 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall_full got=%0h/%0h exp=4/0", fifo_count, bus.imem_req); end
    checks++; if (bus.pc_out !== 32'h0400_0004 || bus.instr !== 32'h1234_5600) begin failures++; $display("FAIL stall_head got=%0h/%0h exp=4000004/12345600", bus.pc_out, bus.instr); end
    bus.instr_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h04) begin failures++; $display("FAIL resume_req got=%0h/%0h exp=1/4", bus.imem_req, bus.imem_addr); end
    for (int j = 0; j < 8; j++) begin
      e_pc = 32'h0400_0004 + 32'(4 * j);
      checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== e_pc) begin failures++; $display("FAIL resume_pc got=%0h/%0h exp=1/%0h", bus.instr_valid, bus.pc_out, e_pc); end
      tick();
    end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_redirect();
    apply_reset(1'b0);
    repeat (4) tick();
    checks++; if (fifo_count !== 3'd3 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL redir_pre got=%0h/%0h exp=3/0", fifo_count, bus.imem_req); end
    bus.redirect = 1'b1;
    bus.redirect_pc = 30'h0000_0040;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL redir_noreq got=%0h exp=0", bus.imem_req); end
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0h/%0h exp=0/0", fifo_count, bus.instr_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40) begin failures++; $display("FAIL redir_req got=%0h/%0h exp=1/40", bus.imem_req, bus.imem_addr); end
    tick();
    checks++; if (fifo_count !== 3'd0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL redir_stale got=%0h/%0h exp=0/0", fifo_count, bus.instr_valid); end
    tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h0000_0104) begin failures++; $display("FAIL redir_pc got=%0h/%0h exp=1/104", bus.instr_valid, bus.pc_out); end
    checks++; if (bus.instr !== 32'h1234_5640) begin failures++; $display("FAIL redir_instr got=%0h exp=12345640", bus.instr); end
  endtask

  task automatic test_redirect_pop();
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 30'h0000_0080;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1) begin failures++; $display("FAIL rpop_req got=%0h/%0h exp=0/1", bus.imem_req, bus.instr_valid); end
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rpop_flush got=%0h/%0h exp=0/0", fifo_count, bus.instr_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h80) begin failures++; $display("FAIL rpop_addr got=%0h/%0h exp=1/80", bus.imem_req, bus.imem_addr); end
    tick(); tick();
    checks++; if (bus.pc_out !== 32'h0000_0204 || bus.instr !== 32'h1234_5680) begin failures++; $display("FAIL rpop_head got=%0h/%0h exp=204/12345680", bus.pc_out, bus.instr); end
  endtask

  task automatic test_wrap();
    bus.redirect = 1'b1;
    bus.redirect_pc = 30'h3FFF_FFFF;
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'hFF) begin failures++; $display("FAIL wrap_top got=%0h/%0h exp=1/ff", bus.imem_req, bus.imem_addr); end
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin failures++; $display("FAIL wrap_zero got=%0h/%0h exp=1/0", bus.imem_req, bus.imem_addr); end
    tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h0 || bus.instr !== 32'h1234_56FF) begin failures++; $display("FAIL wrap_h0 got=%0h/%0h/%0h exp=1/0/123456ff", bus.instr_valid, bus.pc_out, bus.instr); end
    tick();
    checks++; if (bus.pc_out !== 32'h4 || bus.instr !== 32'h1234_5600) begin failures++; $display("FAIL wrap_h1 got=%0h/%0h exp=4/12345600", bus.pc_out, bus.instr); end
  endtask

  task automatic test_async_reset();
    bus.instr_ready = 1'b0;
    repeat (8) tick();
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ar_full got=%0h exp=4", fifo_count); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL ar_clear got=%0h/%0h exp=0/0", bus.instr_valid, fifo_count); end
    checks++; if (bus.imem_req !== 1'b0 || bus.instr !== 32'h0) begin failures++; $display("FAIL ar_out got=%0h/%0h exp=0/0", bus.imem_req, bus.instr); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin failures++; $display("FAIL ar_restart got=%0h/%0h exp=1/0", bus.imem_req, bus.imem_addr); end
    tick(); tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h0400_0004) begin failures++; $display("FAIL ar_head got=%0h/%0h exp=1/4000004", bus.instr_valid, bus.pc_out); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
